ctrl_pipe: RTL and testbench
============================

# ctrl_pipe

- Carries the per-instruction control word from the ID-stage control decoder through the ID/EX, EX/MEM and MEM/WB pipeline registers, so each stage sees the control bits of the instruction it is executing.
- Detects load-use and RAW hazards against the instruction in ID, requests a stall and inserts a bubble.
- Squashes the ID/EX slot on a taken-branch flush.
- Sits between the decoder and the EX/MEM/WB datapath. It is the consumer end of the decoder's control interface.

## Interface
Parameters:
- RW, 5, register-index width.

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; synchronous, active-high
- op_i  in  7  ID-stage opcode, used only to decide rs1/rs2 usage
- rs1_i, rs2_i, rd_i  in  RW each  ID-stage register fields
- branch_i, memread_i, memwrite_i, memtoreg_i, alusrc_i, regwrite_i  in  1 each  decoder control bits
- aluop_i  in  2  decoder ALU op
- flush_i  in  1  branch resolved taken this cycle
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- ex_aluop_o  out  2  EX-stage ALU op; ex_alusrc_o  out  1  EX-stage ALU source select
- mem_branch_o, mem_memread_o, mem_memwrite_o  out  1 each  MEM-stage controls
- wb_memtoreg_o, wb_regwrite_o  out  1 each  WB-stage controls
- ex_rd_o, mem_rd_o, wb_rd_o  out  RW each  destination register per stage
- fwd_a_o, fwd_b_o  out  2 each  forwarding selects (only with CTRL_PIPE_FWD_EN)

## Operation
- Three register banks: IDEX {all control bits, rs1, rs2, rd}, EXMEM {branch, memread, memwrite, memtoreg, regwrite, rd}, MEMWB {memtoreg, regwrite, rd}.
- EXMEM and MEMWB advance every cycle, with no back-pressure.

Source usage:
- use_rs1 = op_i ∈ {0110011, 0000011, 0100011, 1100011, 0010011}.
- use_rs2 = op_i ∈ {0110011, 0100011, 1100011}.
- A match requires the source to be used, the source index to be nonzero, and the source index to equal the stage rd.

Hazard:
- With forwarding: hazard = IDEX.memread & match(IDEX.rd).
- Without forwarding: hazard = (IDEX.regwrite & match(IDEX.rd)) | (EXMEM.regwrite & match(EXMEM.rd)).
- The WB stage never causes a hazard, because the register file is write-before-read.

Stall and flush:
- stall_o = hazard & ~flush_i.
- A taken branch discards the ID instruction, so no stall is requested for it.

IDEX next-state:
- If hazard | flush_i: load a bubble (all control bits 0, rd = 0, rs1 = rs2 = 0).
- Otherwise: capture the *_i inputs.
- Because the bubble clears memread and regwrite, one bubble resolves a load-use hazard. Without forwarding, a back-to-back RAW dependency takes two bubbles.

Forwarding (per operand, using IDEX.rs1 for a and IDEX.rs2 for b):
- 2'b10 if EXMEM.regwrite & EXMEM.rd ≠ 0 & EXMEM.rd == rs.
- Else 2'b01 if MEMWB.regwrite & MEMWB.rd ≠ 0 & MEMWB.rd == rs.
- Else 2'b00.
- EX/MEM has priority over MEM/WB.

## Timing
- Reset (rst_i high at an edge) clears all three banks to zero.
- After reset, every registered output is 0. stall_o and fwd_* evaluate to 0 while the banks are zero.
- Reset mid-operation discards all in-flight control words in that same edge.
- Latency: control presented at ID in cycle n appears on ex_* in n+1, mem_* in n+2, wb_* in n+3.
- stall_o and fwd_* are combinational in the same cycle. There is no path from the ID inputs to fwd_*.
- If flush_i and a hazard occur together: one bubble is inserted and stall_o = 0.
- A bubble entering EX reaches MEM and WB as all-zero control in the following cycles.

## Configuration
- CTRL_PIPE_FWD_EN defined: forwarding logic and the fwd_a_o/fwd_b_o ports exist; only load-use causes a stall.
- CTRL_PIPE_FWD_EN undefined: the fwd ports are absent and the stall rule covers the IDEX and EXMEM producers as above.

## Structure
- Shared package ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_ADDI
  - ALUOP_* codes: 00, 01, 10, 11
  - FWD_REG = 00, FWD_MEMWB = 01, FWD_EXMEM = 10
  - a ctrl_word struct for the staged control bits
- One sub-module, hazard_detect: combinational. It computes use_rs1/use_rs2, the matches and the hazard. ctrl_pipe owns the registers and the forwarding mux selects.

## Test plan
1. Reset: drive rst_i high for 2 cycles with nonzero inputs → all outputs 0, stall_o = 0.
2. Pipeline flow: R-type (op 0110011, rd = 3, aluop = 10, regwrite = 1) at cycle 0 → ex_aluop_o = 10 at cycle 1, mem_rd_o = 3 at cycle 2, wb_regwrite_o = 1 at cycle 3.
3. Load-use: load rd = 5, then R-type with rs2 = 5 → stall_o = 1 for exactly one cycle, one all-zero bubble in EX. With FWD_EN, fwd_b_o = 01 when the R-type is in EX.
4. Forwarding priority (FWD_EN): addi rd = 7, addi rd = 7, add rs1 = 7 → fwd_a_o = 10 when the add is in EX, not 01.
5. x0 and rs2 usage: load rd = 0 followed by add rs1 = 0 → no stall. addi whose rs2 field equals a prior load rd → no stall.
6. Flush priority: load-use hazard with flush_i = 1 in the same cycle → stall_o = 0, IDEX bubble. Without FWD_EN, RAW on the previous instruction → stall_o high for 2 cycles.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: opcode constants, ALU op codes,
// forwarding select codes and the staged control word.
package ctrl_pkg;

  // Opcodes that matter for source-register usage
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;

  // ALU operation codes produced by the decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // Forwarding mux selects for the EX-stage operands
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Control bits that travel with an instruction through the pipeline
  typedef struct packed {
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
  } ctrl_word_t;

  // A bubble is simply an all-zero control word
  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-stage control interface between the decoder (master) and the control
// pipeline (slave). The decoder presents the instruction's register fields and
// control bits; the pipeline answers with a stall request.
interface ctrl_pipe_if #(
  parameter int RW = 5
);
  logic [6:0]    op_i;
  logic [RW-1:0] rs1_i;
  logic [RW-1:0] rs2_i;
  logic [RW-1:0] rd_i;
  logic          branch_i;
  logic          memread_i;
  logic          memwrite_i;
  logic          memtoreg_i;
  logic          alusrc_i;
  logic          regwrite_i;
  logic [1:0]    aluop_i;
  logic          stall_o;

  modport master (
    output op_i, rs1_i, rs2_i, rd_i,
    output branch_i, memread_i, memwrite_i, memtoreg_i, alusrc_i, regwrite_i, aluop_i,
    input  stall_o
  );

  modport slave (
    input  op_i, rs1_i, rs2_i, rd_i,
    input  branch_i, memread_i, memwrite_i, memtoreg_i, alusrc_i, regwrite_i, aluop_i,
    output stall_o
  );
endinterface

// File: rtl/hazard_detect.sv
// Combinational hazard detector for the instruction in ID.
// With CTRL_PIPE_FWD_EN defined only a load in EX can cause a hazard;
// otherwise any register-writing producer in EX or MEM does.
module hazard_detect
  import ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [6:0]    op,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
`ifdef CTRL_PIPE_FWD_EN
  input  logic          idex_memread,
`else
  input  logic          idex_regwrite,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
`endif
  input  logic [RW-1:0] idex_rd,
  output logic          hazard
);

  logic use_rs1;
  logic use_rs2;
  logic match_idex;
`ifndef CTRL_PIPE_FWD_EN
  logic match_exmem;
`endif

  // A source matches a producer only if it is actually read and is not x0
  function automatic logic src_match(input logic used, input logic [RW-1:0] rs,
                                     input logic [RW-1:0] rd);
    return used && (rs != '0) && (rs == rd);
  endfunction

  // Decide which source fields the ID opcode really reads
  always_comb begin
    use_rs1 = op inside {OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH, OP_ADDI};
    use_rs2 = op inside {OP_RTYPE, OP_STORE, OP_BRANCH};
  end

  // Compare the used sources against each producer's destination
  always_comb begin
    match_idex = src_match(use_rs1, rs1, idex_rd) | src_match(use_rs2, rs2, idex_rd);
`ifndef CTRL_PIPE_FWD_EN
    match_exmem = src_match(use_rs1, rs1, exmem_rd) | src_match(use_rs2, rs2, exmem_rd);
`endif
  end

  // WB never appears here: the register file writes before it is read
  always_comb begin
    hazard = 1'b0;
`ifdef CTRL_PIPE_FWD_EN
    hazard = idex_memread & match_idex;
`else
    hazard = (idex_regwrite & match_idex) | (exmem_regwrite & match_exmem);
`endif
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control pipeline: stages the decoder's control word through ID/EX, EX/MEM
// and MEM/WB, requests stalls on hazards, inserts bubbles and squashes the
// ID/EX slot on a taken-branch flush.
// Optional feature macro: CTRL_PIPE_FWD_EN adds the EX-operand forwarding
// selects (fwd_a_o/fwd_b_o) and relaxes stalls to load-use only.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  ctrl_pipe_if.slave    id,
  input  logic          flush_i,
  output logic [1:0]    ex_aluop_o,
  output logic          ex_alusrc_o,
  output logic          mem_branch_o,
  output logic          mem_memread_o,
  output logic          mem_memwrite_o,
  output logic          wb_memtoreg_o,
  output logic          wb_regwrite_o,
  output logic [RW-1:0] ex_rd_o,
  output logic [RW-1:0] mem_rd_o,
`ifdef CTRL_PIPE_FWD_EN
  output logic [1:0]    fwd_a_o,
  output logic [1:0]    fwd_b_o,
`endif
  output logic [RW-1:0] wb_rd_o
);

  ctrl_word_t    id_ctrl;
  logic          hazard;

  ctrl_word_t    idex_ctrl_p0;
  logic [RW-1:0] idex_rd_p0;
`ifdef CTRL_PIPE_FWD_EN
  // Source indices are only needed to steer the forwarding muxes
  logic [RW-1:0] idex_rs1_p0;
  logic [RW-1:0] idex_rs2_p0;
`endif

  logic          exmem_branch_p1;
  logic          exmem_memread_p1;
  logic          exmem_memwrite_p1;
  logic          exmem_memtoreg_p1;
  logic          exmem_regwrite_p1;
  logic [RW-1:0] exmem_rd_p1;

  logic          memwb_memtoreg_p2;
  logic          memwb_regwrite_p2;
  logic [RW-1:0] memwb_rd_p2;

  // Pack the decoder's loose control bits into one word
  always_comb begin
    id_ctrl = CTRL_BUBBLE;
    id_ctrl.branch   = id.branch_i;
    id_ctrl.memread  = id.memread_i;
    id_ctrl.memwrite = id.memwrite_i;
    id_ctrl.memtoreg = id.memtoreg_i;
    id_ctrl.alusrc   = id.alusrc_i;
    id_ctrl.regwrite = id.regwrite_i;
    id_ctrl.aluop    = id.aluop_i;
  end

  hazard_detect #(
    .RW(RW)
  ) u_hazard (
    .op             (id.op_i),
    .rs1            (id.rs1_i),
    .rs2            (id.rs2_i),
`ifdef CTRL_PIPE_FWD_EN
    .idex_memread   (idex_ctrl_p0.memread),
`else
    .idex_regwrite  (idex_ctrl_p0.regwrite),
    .exmem_regwrite (exmem_regwrite_p1),
    .exmem_rd       (exmem_rd_p1),
`endif
    .idex_rd        (idex_rd_p0),
    .hazard         (hazard)
  );

  // A flushed ID instruction is discarded, so holding it would be pointless
  assign id.stall_o = hazard & ~flush_i;

  // ---- ID -> EX boundary: bubble on hazard or flush, else capture ID ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_ctrl_p0 <= CTRL_BUBBLE;
      idex_rd_p0   <= '0;
`ifdef CTRL_PIPE_FWD_EN
      idex_rs1_p0  <= '0;
      idex_rs2_p0  <= '0;
`endif
    end else if (hazard || flush_i) begin
      idex_ctrl_p0 <= CTRL_BUBBLE;
      idex_rd_p0   <= '0;
`ifdef CTRL_PIPE_FWD_EN
      idex_rs1_p0  <= '0;
      idex_rs2_p0  <= '0;
`endif
    end else begin
      idex_ctrl_p0 <= id_ctrl;
      idex_rd_p0   <= id.rd_i;
`ifdef CTRL_PIPE_FWD_EN
      idex_rs1_p0  <= id.rs1_i;
      idex_rs2_p0  <= id.rs2_i;
`endif
    end
  end

  // ---- EX -> MEM and MEM -> WB boundaries: advance every cycle ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exmem_branch_p1   <= 1'b0;
      exmem_memread_p1  <= 1'b0;
      exmem_memwrite_p1 <= 1'b0;
      exmem_memtoreg_p1 <= 1'b0;
      exmem_regwrite_p1 <= 1'b0;
      exmem_rd_p1       <= '0;
      memwb_memtoreg_p2 <= 1'b0;
      memwb_regwrite_p2 <= 1'b0;
      memwb_rd_p2       <= '0;
    end else begin
      exmem_branch_p1   <= idex_ctrl_p0.branch;
      exmem_memread_p1  <= idex_ctrl_p0.memread;
      exmem_memwrite_p1 <= idex_ctrl_p0.memwrite;
      exmem_memtoreg_p1 <= idex_ctrl_p0.memtoreg;
      exmem_regwrite_p1 <= idex_ctrl_p0.regwrite;
      exmem_rd_p1       <= idex_rd_p0;
      memwb_memtoreg_p2 <= exmem_memtoreg_p1;
      memwb_regwrite_p2 <= exmem_regwrite_p1;
      memwb_rd_p2       <= exmem_rd_p1;
    end
  end

  // Per-stage control outputs straight from the banks
  always_comb begin
    ex_aluop_o     = idex_ctrl_p0.aluop;
    ex_alusrc_o    = idex_ctrl_p0.alusrc;
    ex_rd_o        = idex_rd_p0;
    mem_branch_o   = exmem_branch_p1;
    mem_memread_o  = exmem_memread_p1;
    mem_memwrite_o = exmem_memwrite_p1;
    mem_rd_o       = exmem_rd_p1;
    wb_memtoreg_o  = memwb_memtoreg_p2;
    wb_regwrite_o  = memwb_regwrite_p2;
    wb_rd_o        = memwb_rd_p2;
  end

`ifdef CTRL_PIPE_FWD_EN
  // The younger producer (EX/MEM) holds the newest value, so it wins
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] rs,
                                         input logic exmem_wr, input logic [RW-1:0] exmem_rd,
                                         input logic memwb_wr, input logic [RW-1:0] memwb_rd);
    if (exmem_wr && (exmem_rd != '0) && (exmem_rd == rs)) return FWD_EXMEM;
    if (memwb_wr && (memwb_rd != '0) && (memwb_rd == rs)) return FWD_MEMWB;
    return FWD_REG;
  endfunction

  // Operand forwarding selects depend only on registered state
  always_comb begin
    fwd_a_o = fwd_sel(idex_rs1_p0, exmem_regwrite_p1, exmem_rd_p1,
                      memwb_regwrite_p2, memwb_rd_p2);
    fwd_b_o = fwd_sel(idex_rs2_p0, exmem_regwrite_p1, exmem_rd_p1,
                      memwb_regwrite_p2, memwb_rd_p2);
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe: directed scenarios followed by random instruction
// streams, checked by a scoreboard against an instruction-level model.
module tb_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.RW(RW)) id_bus ();

  logic [1:0]    ex_aluop;
  logic          ex_alusrc;
  logic          mem_branch, mem_memread, mem_memwrite;
  logic          wb_memtoreg, wb_regwrite;
  logic [RW-1:0] ex_rd, mem_rd, wb_rd;
`ifdef CTRL_PIPE_FWD_EN
  logic [1:0]    fwd_a, fwd_b;
`endif

  ctrl_pipe #(.RW(RW)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id             (id_bus),
    .flush_i        (flush),
    .ex_aluop_o     (ex_aluop),
    .ex_alusrc_o    (ex_alusrc),
    .mem_branch_o   (mem_branch),
    .mem_memread_o  (mem_memread),
    .mem_memwrite_o (mem_memwrite),
    .wb_memtoreg_o  (wb_memtoreg),
    .wb_regwrite_o  (wb_regwrite),
    .ex_rd_o        (ex_rd),
    .mem_rd_o       (mem_rd),
`ifdef CTRL_PIPE_FWD_EN
    .fwd_a_o        (fwd_a),
    .fwd_b_o        (fwd_b),
`endif
    .wb_rd_o        (wb_rd)
  );

  typedef struct packed {
    logic [6:0]    op;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic [RW-1:0] rd;
    ctrl_word_t    c;
  } instr_t;

  typedef struct packed {
    logic          stall;
    logic [1:0]    aluop;
    logic          alusrc;
    logic          mbranch, mmemread, mmemwrite;
    logic          wmemtoreg, wregwrite;
    logic [RW-1:0] exrd, memrd, wbrd;
    logic [1:0]    fa, fb;
  } exp_t;

  exp_t   sb[$];
  // Model: instructions occupying EX, MEM, WB (index 0 = EX, youngest)
  instr_t flow[$];
  int vectors = 0;
  int miscompares = 0;

  // Does instruction i actually read architectural register r (x0 never counts)?
  function automatic bit reads(input instr_t i, input logic [RW-1:0] r);
    bit u1, u2;
    u1 = (i.op == OP_RTYPE) || (i.op == OP_LOAD) || (i.op == OP_STORE) ||
         (i.op == OP_BRANCH) || (i.op == OP_ADDI);
    u2 = (i.op == OP_RTYPE) || (i.op == OP_STORE) || (i.op == OP_BRANCH);
    return (r != 0) && ((u1 && i.rs1 == r) || (u2 && i.rs2 == r));
  endfunction

  // Where the EX instruction should take source register rs from
  function automatic logic [1:0] fsrc(input logic [RW-1:0] rs);
    if (flow[1].c.regwrite && flow[1].rd != 0 && flow[1].rd == rs) return 2'b10;
    if (flow[2].c.regwrite && flow[2].rd != 0 && flow[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Build an instruction with decoder-like control bits for its opcode
  function automatic instr_t mk(input logic [6:0] op, input logic [RW-1:0] a,
                                input logic [RW-1:0] b, input logic [RW-1:0] d);
    instr_t i;
    i = '0;
    i.op = op; i.rs1 = a; i.rs2 = b; i.rd = d;
    case (op)
      OP_LOAD:   begin i.c.memread = 1; i.c.memtoreg = 1; i.c.alusrc = 1; i.c.regwrite = 1; i.c.aluop = ALUOP_ADD; end
      OP_STORE:  begin i.c.memwrite = 1; i.c.alusrc = 1; i.c.aluop = ALUOP_ADD; end
      OP_BRANCH: begin i.c.branch = 1; i.c.aluop = ALUOP_SUB; end
      OP_RTYPE:  begin i.c.regwrite = 1; i.c.aluop = ALUOP_FUNCT; end
      OP_ADDI:   begin i.c.regwrite = 1; i.c.alusrc = 1; i.c.aluop = ALUOP_IMM; end
      default:   i.c = '0;
    endcase
    return i;
  endfunction

  function automatic instr_t rand_instr();
    logic [6:0] ops[7];
    instr_t i;
    ops[0] = OP_RTYPE; ops[1] = OP_LOAD; ops[2] = OP_STORE; ops[3] = OP_BRANCH;
    ops[4] = OP_ADDI;  ops[5] = 7'b0110111; ops[6] = 7'b1101111;
    i = mk(ops[$urandom_range(0, 6)], RW'($urandom_range(0, 7)),
           RW'($urandom_range(0, 7)), RW'($urandom_range(0, 7)));
    if ($urandom_range(0, 3) == 0) i.c = ctrl_word_t'($urandom);
    return i;
  endfunction

  // One cycle: drive ID, record expected outputs for this cycle, advance model
  task automatic step(input instr_t ins, input bit fl, input bit rs, output bit st);
    exp_t e;
    bit hz;
    @(posedge clk);
    #1;
    id_bus.op_i = ins.op;  id_bus.rs1_i = ins.rs1; id_bus.rs2_i = ins.rs2; id_bus.rd_i = ins.rd;
    id_bus.branch_i = ins.c.branch;     id_bus.memread_i = ins.c.memread;
    id_bus.memwrite_i = ins.c.memwrite; id_bus.memtoreg_i = ins.c.memtoreg;
    id_bus.alusrc_i = ins.c.alusrc;     id_bus.regwrite_i = ins.c.regwrite;
    id_bus.aluop_i = ins.c.aluop;
    flush = fl;
    rst = rs;
`ifdef CTRL_PIPE_FWD_EN
    hz = flow[0].c.memread && reads(ins, flow[0].rd);
`else
    hz = (flow[0].c.regwrite && reads(ins, flow[0].rd)) ||
         (flow[1].c.regwrite && reads(ins, flow[1].rd));
`endif
    st = hz && !fl;
    e = '0;
    e.stall = st;
    e.aluop = flow[0].c.aluop; e.alusrc = flow[0].c.alusrc; e.exrd = flow[0].rd;
    e.mbranch = flow[1].c.branch; e.mmemread = flow[1].c.memread;
    e.mmemwrite = flow[1].c.memwrite; e.memrd = flow[1].rd;
    e.wmemtoreg = flow[2].c.memtoreg; e.wregwrite = flow[2].c.regwrite; e.wbrd = flow[2].rd;
    e.fa = fsrc(flow[0].rs1);
    e.fb = fsrc(flow[0].rs2);
    sb.push_back(e);
    if (rs) begin
      flow = {};
      repeat (3) flow.push_back('0);
    end else begin
      flow.push_front((hz || fl) ? instr_t'('0) : ins);
      void'(flow.pop_back());
    end
  endtask

  // Issue an instruction, re-presenting it while the pipeline asks for a stall
  task automatic send(input instr_t ins, input bit fl);
    bit st;
    int n;
    n = 0;
    step(ins, fl, 1'b0, st);
    while (st && n < 4) begin
      step(ins, 1'b0, 1'b0, st);
      n++;
    end
  endtask

  task automatic nops(input int n);
    repeat (n) send(mk(7'b0, 0, 0, 0), 1'b0);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare on negedge
  exp_t m;
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        m = sb.pop_front();
        vectors++;
        chk("stall", 8'(id_bus.stall_o), 8'(m.stall));
        chk("ex_aluop", 8'(ex_aluop), 8'(m.aluop));
        chk("ex_alusrc", 8'(ex_alusrc), 8'(m.alusrc));
        chk("ex_rd", 8'(ex_rd), 8'(m.exrd));
        chk("mem_branch", 8'(mem_branch), 8'(m.mbranch));
        chk("mem_memread", 8'(mem_memread), 8'(m.mmemread));
        chk("mem_memwrite", 8'(mem_memwrite), 8'(m.mmemwrite));
        chk("mem_rd", 8'(mem_rd), 8'(m.memrd));
        chk("wb_memtoreg", 8'(wb_memtoreg), 8'(m.wmemtoreg));
        chk("wb_regwrite", 8'(wb_regwrite), 8'(m.wregwrite));
        chk("wb_rd", 8'(wb_rd), 8'(m.wbrd));
`ifdef CTRL_PIPE_FWD_EN
        chk("fwd_a", 8'(fwd_a), 8'(m.fa));
        chk("fwd_b", 8'(fwd_b), 8'(m.fb));
`endif
      end
    end
  end

  initial begin
    bit st;
    instr_t cur;
    int w;
    repeat (3) flow.push_back('0);
    id_bus.op_i = OP_LOAD; id_bus.rs1_i = 5'd1; id_bus.rs2_i = 5'd2; id_bus.rd_i = 5'd3;
    id_bus.branch_i = 1; id_bus.memread_i = 1; id_bus.memwrite_i = 1; id_bus.memtoreg_i = 1;
    id_bus.alusrc_i = 1; id_bus.regwrite_i = 1; id_bus.aluop_i = 2'b11;

    // Reset held with busy inputs
    step(mk(OP_LOAD, 1, 2, 3), 1'b1, 1'b1, st);
    step(mk(OP_RTYPE, 3, 3, 3), 1'b0, 1'b1, st);

    // Plain flow of an R-type
    send(mk(OP_RTYPE, 1, 2, 3), 1'b0);
    nops(3);

    // Load-use on rs2
    send(mk(OP_LOAD, 1, 0, 5), 1'b0);
    send(mk(OP_RTYPE, 6, 5, 7), 1'b0);
    nops(3);

    // Two producers of the same register, then a consumer
    send(mk(OP_ADDI, 1, 0, 7), 1'b0);
    send(mk(OP_ADDI, 2, 0, 7), 1'b0);
    send(mk(OP_RTYPE, 7, 0, 8), 1'b0);
    nops(3);

    // x0 never creates a hazard; addi ignores its rs2 field
    send(mk(OP_LOAD, 1, 0, 0), 1'b0);
    send(mk(OP_RTYPE, 0, 0, 4), 1'b0);
    nops(3);
    send(mk(OP_LOAD, 1, 0, 5), 1'b0);
    send(mk(OP_ADDI, 1, 5, 6), 1'b0);
    nops(3);

    // Flush together with a load-use hazard, then a back-to-back RAW
    send(mk(OP_LOAD, 1, 0, 5), 1'b0);
    send(mk(OP_RTYPE, 1, 5, 6), 1'b1);
    nops(3);
    send(mk(OP_ADDI, 1, 0, 4), 1'b0);
    send(mk(OP_RTYPE, 4, 2, 9), 1'b0);
    nops(3);

    // Random stream with occasional flushes and mid-run resets
    cur = rand_instr();
    for (int k = 0; k < 3000; k++) begin
      step(cur, ($urandom_range(0, 7) == 0), ($urandom_range(0, 149) == 0), st);
      if (!st) cur = rand_instr();
    end

    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
